bh_host_ctrl: RTL and testbench

Host-side run controller and memory arbiter for the BrainHack core. It sits between a host command port (debug/loader link), the core, and the single-port tape and program memories. It starts and stops the core at instruction boundaries, single-steps it, and lends the memories to the host while the core is halted so the host can load programs and read or write tape cells.

---
 rtl/bh_host_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_bh_host_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bh_host_ctrl.sv
// Host run controller / memory arbiter for the BrainHack core; cmd rsp 1-2 cycles after accept, HALT waits for an instruction boundary.
// Single outstanding command, no rsp backpressure; optional single-step op guarded by BH_STEP_EN.
module bh_host_ctrl #(
  parameter int TAPE_AW = 8,
  parameter int TAPE_DW = 8,
  parameter int PRG_AW  = 8,
  parameter int INSTR_W = 3
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_cmd_valid,
  output logic               o_cmd_ready,
  input  logic [2:0]         i_cmd_op,
  input  logic [7:0]         i_cmd_addr,
  input  logic [7:0]         i_cmd_data,
  output logic               o_rsp_valid,
  output logic               o_rsp_err,
  output logic [TAPE_DW-1:0] o_rsp_data,
  output logic               o_core_en,
  output logic               o_halted,
  input  logic               i_core_boundary,
  input  logic               i_core_tape_in,
  input  logic [TAPE_AW-1:0] i_core_tape_addr,
  input  logic [TAPE_DW-1:0] i_core_tape_data,
  input  logic [PRG_AW-1:0]  i_core_prgmem_addr,
  output logic               o_tape_in,
  output logic [TAPE_AW-1:0] o_tape_addr,
  output logic [TAPE_DW-1:0] o_tape_data,
  input  logic [TAPE_DW-1:0] i_tape_q,
  output logic               o_prgmem_in,
  output logic [PRG_AW-1:0]  o_prgmem_addr,
  output logic [INSTR_W-1:0] o_prgmem_data
);

  localparam logic [2:0] OP_HALT    = 3'd0;
  localparam logic [2:0] OP_RUN     = 3'd1;
  localparam logic [2:0] OP_PRG_WR  = 3'd2;
  localparam logic [2:0] OP_TAPE_WR = 3'd3;
  localparam logic [2:0] OP_TAPE_RD = 3'd4;
`ifdef BH_STEP_EN
  localparam logic [2:0] OP_STEP    = 3'd5;
`endif

  typedef enum logic [2:0] {
    S_HALTED,
    S_RUN,
    S_DRAIN,
    S_ACCESS,
    S_RSP
`ifdef BH_STEP_EN
    , S_STEP
`endif
  } state_t;

  state_t             r_state;
  state_t             w_nxt;
  logic               w_ready;
  logic               w_acc;
  logic               w_core_owns;
  logic               w_rsp_set;
  logic               w_rsp_err;
  logic               r_rsp_vld;
  logic               r_rsp_err;
  logic [2:0]         r_op;
  logic [7:0]         r_addr;
  logic [7:0]         r_data;
  logic [TAPE_DW-1:0] r_rd_dat;

  // Ready is held low during a pending rsp pulse so responses never run back to back.
  assign w_ready = ((r_state == S_HALTED) || (r_state == S_RUN)) && !r_rsp_vld;
  assign w_acc   = i_cmd_valid && w_ready;

  assign w_core_owns = (r_state == S_RUN) || (r_state == S_DRAIN)
`ifdef BH_STEP_EN
                       || (r_state == S_STEP)
`endif
                       ;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state <= S_HALTED;
    end else begin
      r_state <= w_nxt;
    end
  end

  always_comb begin
    w_nxt     = r_state;
    w_rsp_set = 1'b0;
    w_rsp_err = 1'b0;
    case (r_state)
      S_HALTED: begin
        if (w_acc) begin
          case (i_cmd_op)
            OP_HALT: w_rsp_set = 1'b1;
            OP_RUN: begin
              w_nxt     = S_RUN;
              w_rsp_set = 1'b1;
            end
            OP_PRG_WR, OP_TAPE_WR, OP_TAPE_RD: w_nxt = S_ACCESS;
`ifdef BH_STEP_EN
            OP_STEP: w_nxt = S_STEP;
`endif
            default: begin
              w_rsp_set = 1'b1;
              w_rsp_err = 1'b1;
            end
          endcase
        end
      end
      S_RUN: begin
        if (w_acc) begin
          case (i_cmd_op)
            OP_HALT: begin
              w_nxt     = i_core_boundary ? S_HALTED : S_DRAIN;
              w_rsp_set = i_core_boundary;
            end
            OP_RUN: w_rsp_set = 1'b1;
            default: begin
              w_rsp_set = 1'b1;
              w_rsp_err = 1'b1;
            end
          endcase
        end
      end
      S_DRAIN: begin
        if (i_core_boundary) begin
          w_nxt     = S_HALTED;
          w_rsp_set = 1'b1;
        end
      end
`ifdef BH_STEP_EN
      S_STEP: begin
        if (i_core_boundary) begin
          w_nxt     = S_HALTED;
          w_rsp_set = 1'b1;
        end
      end
`endif
      S_ACCESS: w_nxt = S_RSP;
      S_RSP:    w_nxt = S_HALTED;
      default:  w_nxt = S_HALTED;
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_rsp_vld <= 1'b0;
      r_rsp_err <= 1'b0;
      r_op      <= 3'd0;
      r_addr    <= 8'd0;
      r_data    <= 8'd0;
      r_rd_dat  <= '0;
    end else begin
      r_rsp_vld <= w_rsp_set;
      r_rsp_err <= w_rsp_err;
      if (w_acc) begin
        r_op   <= i_cmd_op;
        r_addr <= i_cmd_addr;
        r_data <= i_cmd_data;
      end
      if ((r_state == S_ACCESS) && (r_op == OP_TAPE_RD)) begin
        r_rd_dat <= i_tape_q;
      end
    end
  end

  always_comb begin
    o_cmd_ready   = w_ready;
    o_halted      = (r_state == S_HALTED) || (r_state == S_ACCESS) || (r_state == S_RSP);
    o_core_en     = w_core_owns;
    o_rsp_valid   = r_rsp_vld;
    o_rsp_err     = r_rsp_vld && r_rsp_err;
    o_rsp_data    = '0;
    o_tape_in     = 1'b0;
    o_tape_addr   = '0;
    o_tape_data   = '0;
    o_prgmem_in   = 1'b0;
    o_prgmem_addr = '0;
    o_prgmem_data = '0;
    if (w_core_owns) begin
      o_tape_in     = i_core_tape_in;
      o_tape_addr   = i_core_tape_addr;
      o_tape_data   = i_core_tape_data;
      o_prgmem_addr = i_core_prgmem_addr;
    end else if (r_state == S_ACCESS) begin
      if (r_op == OP_PRG_WR) begin
        o_prgmem_in   = 1'b1;
        o_prgmem_addr = PRG_AW'(r_addr);
        o_prgmem_data = INSTR_W'(r_data);
      end else begin
        o_tape_in   = (r_op == OP_TAPE_WR);
        o_tape_addr = TAPE_AW'(r_addr);
        o_tape_data = TAPE_DW'(r_data);
      end
    end else if (r_state == S_RSP) begin
      o_rsp_valid = 1'b1;
      if (r_op == OP_TAPE_RD) begin
        o_rsp_data = r_rd_dat;
      end
    end
  end

endmodule

// File: tb/tb_bh_host_ctrl.sv
// Randomized command stream against a transaction-level model of the host controller.
module tb_bh_host_ctrl;
  logic       i_clock = 1'b0;
  logic       i_reset;
  logic       i_cmd_valid;
  logic       o_cmd_ready;
  logic [2:0] i_cmd_op;
  logic [7:0] i_cmd_addr;
  logic [7:0] i_cmd_data;
  logic       o_rsp_valid;
  logic       o_rsp_err;
  logic [7:0] o_rsp_data;
  logic       o_core_en;
  logic       o_halted;
  logic       i_core_boundary;
  logic       i_core_tape_in;
  logic [7:0] i_core_tape_addr;
  logic [7:0] i_core_tape_data;
  logic [7:0] i_core_prgmem_addr;
  logic       o_tape_in;
  logic [7:0] o_tape_addr;
  logic [7:0] o_tape_data;
  logic [7:0] i_tape_q;
  logic       o_prgmem_in;
  logic [7:0] o_prgmem_addr;
  logic [2:0] o_prgmem_data;

  bh_host_ctrl dut (
    .i_clock(i_clock), .i_reset(i_reset),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready), .i_cmd_op(i_cmd_op),
    .i_cmd_addr(i_cmd_addr), .i_cmd_data(i_cmd_data),
    .o_rsp_valid(o_rsp_valid), .o_rsp_err(o_rsp_err), .o_rsp_data(o_rsp_data),
    .o_core_en(o_core_en), .o_halted(o_halted), .i_core_boundary(i_core_boundary),
    .i_core_tape_in(i_core_tape_in), .i_core_tape_addr(i_core_tape_addr),
    .i_core_tape_data(i_core_tape_data), .i_core_prgmem_addr(i_core_prgmem_addr),
    .o_tape_in(o_tape_in), .o_tape_addr(o_tape_addr), .o_tape_data(o_tape_data),
    .i_tape_q(i_tape_q), .o_prgmem_in(o_prgmem_in), .o_prgmem_addr(o_prgmem_addr),
    .o_prgmem_data(o_prgmem_data)
  );

  always #5 i_clock = ~i_clock;

  logic [7:0] tape_mem [256];
  logic [7:0] ref_tape [256];
  assign i_tape_q = tape_mem[o_tape_addr];
  always @(posedge i_clock) if (o_tape_in) tape_mem[o_tape_addr] <= o_tape_data;

  int n_vec = 0;
  int n_mis = 0;
  bit mdl_run = 1'b0;
  int bnd_period = 4;
  int bnd_ph = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
    end
  endtask

  // Behavioural core: one instruction boundary every bnd_period enabled cycles.
  always @(negedge i_clock) begin
    i_core_tape_addr   = 8'($urandom);
    i_core_tape_data   = 8'($urandom);
    i_core_prgmem_addr = 8'($urandom);
    if (o_core_en) begin
      if (bnd_ph >= bnd_period - 1) begin
        i_core_boundary = 1'b1;
        bnd_ph = 0;
      end else begin
        i_core_boundary = 1'b0;
        bnd_ph++;
      end
    end else begin
      i_core_boundary = 1'($urandom);
    end
  end

  task automatic step();
    @(negedge i_clock);
    #1;
  endtask

  task automatic do_cmd(input logic [2:0] op, input logic [7:0] addr, input logic [7:0] data);
    int guard = 0;
    int rsp_k = -1;
    int first_bnd = -1;
    int en_bnd = 0;
    int tw_n = 0;
    int pw_n = 0;
    int w_k = -1;
    logic [7:0] w_addr = 8'd0;
    logic [7:0] w_dat = 8'd0;
    logic r_err = 1'b0;
    logic [7:0] r_dat = 8'd0;
    logic en_rsp = 1'b0;
    logic hlt_rsp = 1'b0;
    logic en_k1 = 1'b0;
    bit pt_ok = 1'b1;
    bit step_ok;
    int exp_lat = 1;
    logic exp_err = 1'b0;
    logic [7:0] exp_dat = 8'd0;
    bit nxt_run;
    bit is_wr_t = 1'b0;
    bit is_wr_p = 1'b0;
    bit is_step = 1'b0;
`ifdef BH_STEP_EN
    step_ok = 1'b1;
`else
    step_ok = 1'b0;
`endif
    nxt_run = mdl_run;
    while (!o_cmd_ready && guard < 200) begin
      step();
      guard++;
    end
    chk("cmd_ready", o_cmd_ready, 1);
    i_cmd_valid = 1'b1;
    i_cmd_op    = op;
    i_cmd_addr  = addr;
    i_cmd_data  = data;
    for (int k = 0; k < 300; k++) begin
      if (k > 0) begin
        step();
        i_cmd_valid = 1'b0;
      end
      if (o_core_en && i_core_boundary) begin
        if (first_bnd < 0) first_bnd = k;
        en_bnd++;
      end
      if (k == 1) en_k1 = o_core_en;
      if (o_core_en && (o_tape_addr !== i_core_tape_addr || o_prgmem_addr !== i_core_prgmem_addr))
        pt_ok = 1'b0;
      if (o_tape_in) begin
        tw_n++; w_k = k; w_addr = o_tape_addr; w_dat = o_tape_data;
      end
      if (o_prgmem_in) begin
        pw_n++; w_k = k; w_addr = o_prgmem_addr; w_dat = {5'd0, o_prgmem_data};
      end
      if (k > 0 && o_rsp_valid) begin
        rsp_k = k; r_err = o_rsp_err; r_dat = o_rsp_data;
        en_rsp = o_core_en; hlt_rsp = o_halted;
        break;
      end
    end
    i_cmd_valid = 1'b0;

    if (!mdl_run) begin
      case (op)
        3'd0: nxt_run = 1'b0;
        3'd1: nxt_run = 1'b1;
        3'd2: begin exp_lat = 2; is_wr_p = 1'b1; end
        3'd3: begin exp_lat = 2; is_wr_t = 1'b1; end
        3'd4: begin exp_lat = 2; exp_dat = ref_tape[addr]; end
        3'd5: begin
          if (step_ok) begin
            exp_lat = first_bnd + 1; is_step = 1'b1;
          end else begin
            exp_err = 1'b1;
          end
        end
        default: exp_err = 1'b1;
      endcase
    end else begin
      case (op)
        3'd0: begin exp_lat = first_bnd + 1; nxt_run = 1'b0; end
        3'd1: nxt_run = 1'b1;
        default: exp_err = 1'b1;
      endcase
    end

    chk("rsp_lat", rsp_k, exp_lat);
    chk("rsp_err", r_err, exp_err);
    chk("rsp_data", r_dat, exp_dat);
    chk("en_at_rsp", en_rsp, nxt_run);
    chk("halted_at_rsp", hlt_rsp, !nxt_run);
    chk("tape_wr_cnt", tw_n, is_wr_t);
    chk("prg_wr_cnt", pw_n, is_wr_p);
    if (is_wr_t || is_wr_p) begin
      chk("wr_cycle", w_k, 1);
      chk("wr_addr", w_addr, addr);
      chk("wr_data", w_dat, is_wr_p ? {5'd0, data[2:0]} : data);
    end
    if (is_step) begin
      chk("step_en_k1", en_k1, 1);
      chk("step_insns", en_bnd, 1);
    end
    if (mdl_run) chk("pass_thru", pt_ok, 1);
    if (is_wr_t) ref_tape[addr] = data;
    mdl_run = nxt_run;
    step();
    chk("rsp_gap", o_rsp_valid, 0);
  endtask

  task automatic reset_mid_drain();
    int g = 0;
    if (!mdl_run) begin
      bnd_period = 8;
      do_cmd(3'd1, 8'd0, 8'd0);
    end
    while (!(o_cmd_ready && !i_core_boundary) && g < 50) begin
      step();
      g++;
    end
    chk("drain_setup", o_cmd_ready && !i_core_boundary, 1);
    i_cmd_valid = 1'b1;
    i_cmd_op    = 3'd0;
    step();
    i_cmd_valid = 1'b0;
    chk("drain_en", o_core_en, 1);
    chk("drain_rdy", o_cmd_ready, 0);
    i_reset = 1'b1;
    #1;
    chk("rst_halted", o_halted, 1);
    chk("rst_en", o_core_en, 0);
    chk("rst_rsp", o_rsp_valid, 0);
    chk("rst_rdy", o_cmd_ready, 1);
    step();
    i_reset = 1'b0;
    mdl_run = 1'b0;
    step();
    chk("post_rst_rsp", o_rsp_valid, 0);
  endtask

  initial begin
    logic [2:0] op;
    i_reset = 1'b1;
    i_cmd_valid = 1'b0;
    i_cmd_op = 3'd0;
    i_cmd_addr = 8'd0;
    i_cmd_data = 8'd0;
    i_core_tape_in = 1'b0;
    for (int i = 0; i < 256; i++) begin
      tape_mem[i] = 8'($urandom);
      ref_tape[i] = tape_mem[i];
    end
    repeat (3) step();
    chk("init_rdy", o_cmd_ready, 1);
    chk("init_halted", o_halted, 1);
    chk("init_en", o_core_en, 0);
    chk("init_rsp", o_rsp_valid, 0);
    chk("init_tape_in", o_tape_in, 0);
    chk("init_prg_in", o_prgmem_in, 0);
    i_reset = 1'b0;
    step();

    do_cmd(3'd2, 8'h05, 8'h06);
    do_cmd(3'd3, 8'h10, 8'hA5);
    do_cmd(3'd4, 8'h10, 8'h00);
    do_cmd(3'd7, 8'h00, 8'h00);
    bnd_period = 4;
    do_cmd(3'd1, 8'h00, 8'h00);
    do_cmd(3'd3, 8'h20, 8'h11);
    do_cmd(3'd0, 8'h00, 8'h00);
    do_cmd(3'd4, 8'h20, 8'h00);
    do_cmd(3'd5, 8'h00, 8'h00);
    reset_mid_drain();

    for (int i = 0; i < 400; i++) begin
      if (!mdl_run) bnd_period = $urandom_range(1, 5);
      op = 3'($urandom_range(0, 7));
      if (mdl_run && $urandom_range(0, 2) == 0) op = 3'd0;
      do_cmd(op, 8'($urandom_range(0, 31)), 8'($urandom));
      if (i % 100 == 50) reset_mid_drain();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule
